joybus_rx_frame: RTL and testbench

- Parametrised Joybus receiver. Decodes console-to-controller frames of arbitrary byte length, up to MAX_BYTES, on a single open-drain data line.
- Uses majority-vote bit decoding and terminates each frame on idle, not on command lookahead.
- Presents each frame as one buffered record with a valid/ack handshake and error flags.
- Sits between the line pad and the command dispatcher / controller responder (N64 and GC modes).

---
 rtl/joybus_pkg.sv | 22 ++
 rtl/joybus_line_sync.sv | 46 ++++
 rtl/joybus_rx_frame.sv | 132 +++++++++++++
 tb/tb_joybus_rx_frame.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/joybus_pkg.sv
// Shared Joybus receive types, command byte constants and counter sizing helper.
package joybus_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LOW       = 3'd1,
        HIGH      = 3'd2,
        WAIT_HIGH = 3'd3,
        FINISH    = 3'd4
    } rx_state_t;

    localparam logic [7:0] CMD_STATUS = 8'h00;
    localparam logic [7:0] CMD_POLL   = 8'h40;
    localparam logic [7:0] CMD_ORIGIN = 8'h41;
    localparam logic [7:0] CMD_RESET  = 8'hFF;

    // Width of a per-phase cycle counter that saturates at two bit cells.
    function automatic int bit_cw(input int bit_cyc);
        return $clog2(2 * bit_cyc + 1);
    endfunction

endpackage

// File: rtl/joybus_line_sync.sv
// Two-flop synchroniser for the Joybus line; JOYBUS_RX_GLITCH_FILTER_EN adds a
// 3-cycle stability filter that rejects pulses of 2 cycles or fewer.
module joybus_line_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic rx_line,
    output logic line_s
);

    logic s1, s2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= 1'b1;
            s2 <= 1'b1;
        end else begin
            s1 <= rx_line;
            s2 <= s1;
        end
    end

`ifdef JOYBUS_RX_GLITCH_FILTER_EN
    logic [1:0] stable_cnt;
    logic       filt;

    // Follow s2 only after it has disagreed with the filtered level 3 cycles running.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            filt       <= 1'b1;
            stable_cnt <= '0;
        end else if (s2 == filt) begin
            stable_cnt <= '0;
        end else if (stable_cnt == 2'd2) begin
            filt       <= s2;
            stable_cnt <= '0;
        end else begin
            stable_cnt <= stable_cnt + 2'd1;
        end
    end

    assign line_s = filt;
`else
    assign line_s = s2;
`endif

endmodule

// File: rtl/joybus_rx_frame.sv
// Joybus frame receiver: majority-vote bit decode, idle-terminated frames, one
// buffered record with valid/ack. Optional input filter: JOYBUS_RX_GLITCH_FILTER_EN.
module joybus_rx_frame
    import joybus_pkg::*;
#(
    parameter int BIT_CYC    = 100,
    parameter int MAX_BYTES  = 3,
    parameter int IDLE_CELLS = 2
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             rx_line,
    input  logic                             frame_ack,
    output logic                             frame_valid,
    output logic [8*MAX_BYTES-1:0]           frame_data,
    output logic [$clog2(MAX_BYTES+1)-1:0]   frame_len,
    output logic                             err_timeout,
    output logic                             err_framing,
    output logic                             err_overflow,
    output logic                             err_overrun,
    output logic                             busy
);

    localparam int CW      = bit_cw(BIT_CYC);
    localparam int DW      = 8 * MAX_BYTES;
    localparam int LW      = $clog2(MAX_BYTES + 1);
    localparam int BIT_MAX = DW + 1;
    localparam int BC_SAT  = DW + 2;
    localparam int BCW     = $clog2(BC_SAT + 1);
    localparam int END_RAW = IDLE_CELLS * BIT_CYC;
    localparam logic [CW-1:0] CNT_SAT = CW'(2 * BIT_CYC);
    // The high counter saturates at two cells, so the idle threshold is clamped to it.
    localparam logic [CW-1:0] END_CNT = CW'((END_RAW < 2 * BIT_CYC) ? END_RAW : 2 * BIT_CYC);

    rx_state_t      state;
    logic           line_s;
    logic           bit_val;
    logic [CW-1:0]  low_cnt, high_cnt, high_nxt;
    logic [BCW-1:0] bit_cnt, bit_inc, pay_bits;
    // The stop bit is never shifted in, so payload capacity is all the register needs.
    logic [DW-1:0]  shreg, aligned;

    joybus_line_sync u_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .rx_line (rx_line),
        .line_s  (line_s)
    );

    always_comb begin
        bit_val  = high_cnt > low_cnt;
        high_nxt = (high_cnt == CNT_SAT) ? high_cnt : high_cnt + CW'(1);
        bit_inc  = (bit_cnt == BCW'(BC_SAT)) ? bit_cnt : bit_cnt + BCW'(1);
        pay_bits = bit_cnt - BCW'(1);
        aligned  = shreg << (BCW'(DW) - pay_bits);
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            low_cnt      <= '0;
            high_cnt     <= '0;
            bit_cnt      <= '0;
            shreg        <= '0;
            frame_valid  <= 1'b0;
            frame_data   <= '0;
            frame_len    <= '0;
            err_timeout  <= 1'b0;
            err_framing  <= 1'b0;
            err_overflow <= 1'b0;
            err_overrun  <= 1'b0;
        end else begin
            if (frame_ack) begin
                frame_valid  <= 1'b0;
                err_timeout  <= 1'b0;
                err_framing  <= 1'b0;
                err_overflow <= 1'b0;
                err_overrun  <= 1'b0;
            end
            // Phase counters restart at 1 so the edge cycle itself is counted.
            case (state)
                IDLE: if (!line_s) begin
                    state    <= LOW;
                    low_cnt  <= CW'(1);
                    high_cnt <= '0;
                    bit_cnt  <= '0;
                    shreg    <= '0;
                end
                LOW: if (line_s) begin
                    state    <= HIGH;
                    high_cnt <= CW'(1);
                end else if (low_cnt == CNT_SAT) begin
                    err_timeout <= 1'b1;
                    state       <= WAIT_HIGH;
                end else begin
                    low_cnt <= low_cnt + CW'(1);
                end
                HIGH: if (!line_s) begin
                    shreg    <= {shreg[DW-2:0], bit_val};
                    bit_cnt  <= bit_inc;
                    low_cnt  <= CW'(1);
                    high_cnt <= '0;
                    state    <= LOW;
                end else if (high_nxt == END_CNT) begin
                    bit_cnt <= bit_inc;
                    state   <= FINISH;
                end else begin
                    high_cnt <= high_nxt;
                end
                WAIT_HIGH: if (line_s) state <= IDLE;
                FINISH: begin
                    state <= IDLE;
                    if (bit_cnt > BCW'(BIT_MAX)) begin
                        err_overflow <= 1'b1;
                    end else if (bit_cnt < BCW'(9) || pay_bits[2:0] != 3'd0) begin
                        err_framing <= 1'b1;
                    end else if (frame_valid) begin
                        err_overrun <= 1'b1;
                    end else begin
                        frame_valid <= 1'b1;
                        frame_data  <= aligned;
                        frame_len   <= LW'(pay_bits >> 3);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_joybus_rx_frame.sv
// Scoreboarded bench for joybus_rx_frame: a frame-level model predicts each
// output event, a monitor compares whenever a frame or a new error flag appears.
module tb_joybus_rx_frame;

    localparam int BIT_CYC    = 100;
    localparam int MAX_BYTES  = 3;
    localparam int IDLE_CELLS = 2;
    localparam int DW         = 8 * MAX_BYTES;
    localparam int LW         = $clog2(MAX_BYTES + 1);

    logic          clk = 1'b0, rst_n = 1'b0, rx_line = 1'b1, frame_ack = 1'b0;
    logic          frame_valid, busy;
    logic [DW-1:0] frame_data;
    logic [LW-1:0] frame_len;
    logic          err_timeout, err_framing, err_overflow, err_overrun;
    logic [3:0]    d_errs;

    assign d_errs = {err_timeout, err_framing, err_overflow, err_overrun};

    always #5 clk = ~clk;

    joybus_rx_frame #(.BIT_CYC(BIT_CYC), .MAX_BYTES(MAX_BYTES), .IDLE_CELLS(IDLE_CELLS)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rx_line      (rx_line),
        .frame_ack    (frame_ack),
        .frame_valid  (frame_valid),
        .frame_data   (frame_data),
        .frame_len    (frame_len),
        .err_timeout  (err_timeout),
        .err_framing  (err_framing),
        .err_overflow (err_overflow),
        .err_overrun  (err_overrun),
        .busy         (busy)
    );

    typedef struct { int lo; int hi; } cell_t;
    typedef struct { bit valid; logic [DW-1:0] data; int len; logic [3:0] errs; } snap_t;

    snap_t         exp_q[$];
    cell_t         cq[$];
    int            errors = 0, checks = 0;
    bit            m_valid = 0;
    logic [DW-1:0] m_data = '0;
    int            m_len = 0;
    logic [3:0]    m_errs = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Push a snapshot only when the DUT will show something new.
    task automatic expect_event(input bit load, input logic [3:0] add);
        snap_t s;
        bit fresh;
        fresh  = load || ((add & ~m_errs) != 4'b0);
        m_errs = m_errs | add;
        if (fresh) begin
            s.valid = m_valid; s.data = m_data; s.len = m_len; s.errs = m_errs;
            exp_q.push_back(s);
        end
    endtask

    // Frame rules applied to the decoded cells plus the stop bit.
    task automatic expect_frame(input cell_t cells[$]);
        int nbits;
        nbits = cells.size() + 1;
        if (nbits > MAX_BYTES * 8 + 1)                 expect_event(0, 4'b0010);
        else if (nbits < 9 || (nbits - 1) % 8 != 0)    expect_event(0, 4'b0100);
        else if (m_valid)                              expect_event(0, 4'b0001);
        else begin
            m_valid = 1;
            m_len   = (nbits - 1) / 8;
            m_data  = '0;
            for (int i = 0; i < nbits - 1; i++) m_data[DW-1-i] = (cells[i].hi > cells[i].lo);
            expect_event(1, 4'b0000);
        end
    endtask

    task automatic hold(input bit lvl, input int n);
        rx_line = lvl;
        repeat (n) @(negedge clk);
    endtask

    task automatic drive_cells(input cell_t cells[$]);
        foreach (cells[i]) begin
            hold(1'b0, cells[i].lo);
            hold(1'b1, cells[i].hi);
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("idle_wait", busy, 0);
        repeat (5) @(negedge clk);
    endtask

    task automatic send_frame(input cell_t cells[$]);
        expect_frame(cells);
        drive_cells(cells);
        hold(1'b0, 25);
        hold(1'b1, 10);
        wait_idle();
    endtask

    task automatic push_bit(input bit b, input bit rnd);
        int lo;
        if (rnd) lo = b ? int'($urandom_range(45, 15)) : int'($urandom_range(85, 55));
        else     lo = b ? 25 : 75;
        cq.push_back('{lo: lo, hi: 100 - lo});
    endtask

    task automatic push_byte(input logic [7:0] b, input bit rnd);
        for (int i = 7; i >= 0; i--) push_bit(b[i], rnd);
    endtask

    task automatic do_ack();
        frame_ack = 1'b1;
        @(negedge clk);
        frame_ack = 1'b0;
        m_valid = 0;
        m_errs  = '0;
        check("ack_valid", frame_valid, 0);
        check("ack_errs", d_errs, 0);
    endtask

    initial begin : monitor
        logic       pv;
        logic [3:0] pe;
        snap_t      e;
        pv = 1'b0;
        pe = 4'b0;
        forever begin
            @(negedge clk);
            if (rst_n && ((frame_valid && !pv) || ((d_errs & ~pe) != 4'b0))) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_event: valid=%0b errs=%b, expected no event", frame_valid, d_errs);
                end else begin
                    e = exp_q.pop_front();
                    check("ev_valid", frame_valid, e.valid);
                    check("ev_errs", d_errs, e.errs);
                    if (e.valid) begin
                        check("ev_data", frame_data, e.data);
                        check("ev_len", frame_len, e.len);
                    end
                end
            end
            pv = frame_valid;
            pe = d_errs;
        end
    end

    initial begin : watchdog
        #1500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin : driver
        int n, extra;
        repeat (3) @(negedge clk);
        check("rst_valid", frame_valid, 0);
        check("rst_data", frame_data, 0);
        check("rst_len", frame_len, 0);
        check("rst_errs", d_errs, 0);
        check("rst_busy", busy, 0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // GC poll with nominal timing
        cq.delete(); push_byte(8'h40, 0); push_byte(8'h03, 0); push_byte(8'h00, 0);
        send_frame(cq);
        check("poll_data", frame_data, 24'h400300);
        check("poll_len", frame_len, 3);
        check("poll_errs", d_errs, 0);
        do_ack();

        // Skewed cells, including an exact 50/50 tie
        cq.delete();
        cq.push_back('{lo: 45, hi: 55}); cq.push_back('{lo: 60, hi: 40}); cq.push_back('{lo: 50, hi: 50});
        push_bit(1, 0); push_bit(0, 0); push_bit(1, 0); push_bit(0, 0); push_bit(1, 0);
        send_frame(cq);
        check("skew_data", frame_data, 24'h950000);
        do_ack();

        // Line stuck low mid-byte
        cq.delete(); push_bit(0, 1); push_bit(1, 1); push_bit(0, 1);
        expect_event(0, 4'b1000);
        drive_cells(cq);
        hold(1'b0, 250);
        hold(1'b1, 10);
        wait_idle();
        check("to_flag", err_timeout, 1);
        check("to_novalid", frame_valid, 0);
        cq.delete(); push_byte(8'h00, 0);
        send_frame(cq);
        check("after_to_len", frame_len, 1);
        check("after_to_data", frame_data, 24'h000000);
        do_ack();

        // Four bytes into a three-byte receiver
        cq.delete(); push_byte(8'h40, 0); push_byte(8'h03, 0); push_byte(8'h01, 0); push_byte(8'hAA, 0);
        send_frame(cq);
        check("ovf_novalid", frame_valid, 0);

        // Held frame, second frame overruns
        cq.delete(); push_byte(8'h41, 1);
        send_frame(cq);
        cq.delete(); push_byte(8'h00, 1);
        send_frame(cq);
        check("ovr_flag", err_overrun, 1);
        check("ovr_data", frame_data, 24'h410000);
        do_ack();

        // Reset after five bits
        cq.delete(); repeat (5) push_bit(1, 1);
        drive_cells(cq);
        hold(1'b0, 10);
        rst_n = 1'b0;
        @(negedge clk);
        check("mid_rst_valid", frame_valid, 0);
        check("mid_rst_errs", d_errs, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_data", frame_data, 0);
        m_valid = 0; m_errs = '0; m_data = '0; m_len = 0;
        hold(1'b1, 5);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        cq.delete(); push_byte(8'h00, 0);
        send_frame(cq);
        check("post_rst_len", frame_len, 1);
        do_ack();

        // Short high glitch inside a 0-bit's low phase
        cq.delete();
`ifdef JOYBUS_RX_GLITCH_FILTER_EN
        cq.push_back('{lo: 75, hi: 25});
`else
        cq.push_back('{lo: 36, hi: 2}); cq.push_back('{lo: 37, hi: 25});
`endif
        repeat (7) push_bit(0, 0);
        expect_frame(cq);
        hold(1'b0, 36); hold(1'b1, 2); hold(1'b0, 37); hold(1'b1, 25);
        for (int i = 0; i < 7; i++) begin
            hold(1'b0, 75); hold(1'b1, 25);
        end
        hold(1'b0, 25);
        hold(1'b1, 10);
        wait_idle();
`ifdef JOYBUS_RX_GLITCH_FILTER_EN
        check("glitch_len", frame_len, 1);
`else
        check("glitch_framing", err_framing, 1);
`endif
        if (m_valid) do_ack();

        // Sub-bit pulse only: stop bit alone
        cq.delete();
        expect_frame(cq);
        hold(1'b0, 5);
        hold(1'b1, 10);
        wait_idle();
        check("short_framing", err_framing, 1);

        // Randomized frames
        for (int k = 0; k < 14; k++) begin
            cq.delete();
            if ($urandom_range(5, 0) == 0) begin
                n = int'($urandom_range(10, 1));
                for (int i = 0; i < n; i++) push_bit(1'($urandom), 1);
                expect_event(0, 4'b1000);
                drive_cells(cq);
                hold(1'b0, 250);
                hold(1'b1, 10);
                wait_idle();
            end else begin
                n     = int'($urandom_range(4, 1));
                extra = ($urandom_range(3, 0) == 0) ? int'($urandom_range(7, 1)) : 0;
                for (int i = 0; i < n; i++) push_byte(8'($urandom), 1);
                for (int i = 0; i < extra; i++) push_bit(1'($urandom), 1);
                send_frame(cq);
            end
            if (m_valid && $urandom_range(2, 0) != 0) do_ack();
        end

        repeat (20) @(negedge clk);
        check("queue_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
